// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/inst_loader.sv
// Serial instruction-memory loader: parses a length-prefixed, XOR-checksummed byte
// frame, writes little-endian words from address 0, and releases core reset on success.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iStart,
    input  logic [7:0]    iRxData,
    input  logic          iRxValid,
    output logic          oRxReady,
    output logic          oWrEn,
    output logic [AW-1:0] oWrAddr,
    output logic [31:0]   oWrData,
    output logic          oBusy,
    output logic          oDone,
    output logic          oErr,
    output logic          oCoreRst_n,
    output state_t        oState
);

    // Byte handshake: a byte moves only on a cycle where iRxValid and oRxReady are
    // both high; oRxReady is decoded from state alone, so it never depends on iRxValid.

    state_t      state, state_d;
    logic [15:0] n;
    logic [15:0] k;
    logic [1:0]  idx;
    logic [7:0]  xsum;
    logic [31:0] shreg;
    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic [15:0] len_full;

    assign oRxReady   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign accept     = iRxValid && oRxReady;
    assign start_ok   = iStart && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign last_word  = ((k + 16'd1) == n);
    assign len_full   = {iRxData, n[7:0]};

    assign oWrEn      = (state == WRITE);
    assign oWrAddr    = AW'({k, 2'b00});
    assign oWrData    = shreg;
    assign oBusy      = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign oDone      = (state == DONE);
    assign oErr       = (state == ERR);
    assign oCoreRst_n = (state == DONE);
    assign oState     = state;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (iStart) state_d = LEN0;
            LEN0:  if (accept) state_d = LEN1;
            LEN1: begin
                if (accept) begin
                    if (32'(len_full) > 32'(DEPTH)) state_d = ERR;
                    else if (len_full == 16'd0)     state_d = CSUM;
                    else                            state_d = DATA;
                end
            end
            DATA:  if (accept && (idx == 2'd3)) state_d = WRITE;
            WRITE: state_d = last_word ? CSUM : DATA;
            CSUM:  if (accept) state_d = (iRxData == xsum) ? DONE : ERR;
            DONE:  if (iStart) state_d = LEN0;
            ERR:   if (iStart) state_d = LEN0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state <= IDLE;
            n     <= '0;
            k     <= '0;
            idx   <= '0;
            xsum  <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            if (start_ok) begin
                k    <= '0;
                idx  <= '0;
                xsum <= '0;
            end
            if (accept) begin
                case (state)
                    LEN0: begin
                        n[7:0] <= iRxData;
                        xsum   <= xsum ^ iRxData;
                    end
                    LEN1: begin
                        n[15:8] <= iRxData;
                        xsum    <= xsum ^ iRxData;
                    end
                    DATA: begin
                        // Shift right so the first (least significant) byte lands in [7:0].
                        shreg <= {iRxData, shreg[31:8]};
                        idx   <= idx + 2'd1;
                        xsum  <= xsum ^ iRxData;
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                k   <= k + 16'd1;
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader with a write scoreboard.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iStart;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic        oWrEn;
    logic [31:0] oWrAddr;
    logic [31:0] oWrData;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic        oCoreRst_n;
    state_t      oState;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int wr_run = 0;
    int wr_run_max = 0;

    inst_loader #(.DEPTH(64), .AW(32)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iRxData(iRxData), .iRxValid(iRxValid), .oRxReady(oRxReady),
        .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
        .oCoreRst_n(oCoreRst_n), .oState(oState)
    );

    // clock / reset
    always #5 iClk = ~iClk;

    // write monitor, sampled on the falling edge
    always @(negedge iClk) begin
        if (oWrEn) begin
            obs_q.push_back({oWrAddr, oWrData});
            wr_run = wr_run + 1;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
        end else begin
            wr_run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_frame();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        iRxValid = 1'b0;
        repeat (gap) tick();
        iRxData  = b;
        iRxValid = 1'b1;
        cnt = 0;
        while (!oRxReady && cnt < 20) begin
            tick();
            cnt++;
        end
        if (!oRxReady) check("rx_ready_timeout", 64'(oRxReady), 64'd1);
        tick();
        iRxValid = 1'b0;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        wr_run_max = 0;
    endtask

    task automatic compare_writes(input string tag);
        logic [63:0] o;
        logic [63:0] e;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, o, e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(oState), 64'(IDLE));
        check({tag, "_outs"},
              64'({oRxReady, oWrEn, oBusy, oDone, oErr, oCoreRst_n}), 64'd0);
        check({tag, "_addr"}, 64'(oWrAddr), 64'd0);
        check({tag, "_data"}, 64'(oWrData), 64'd0);
    endtask

    logic [7:0] basic_f[7] = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB2};
    logic [7:0] two_f[11]  = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                               8'h93, 8'h81, 8'h30, 8'h00, 8'h22};

    initial begin
        iRst_n = 1'b0; iStart = 1'b0; iRxData = 8'h00; iRxValid = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        iRst_n = 1'b1;
        tick();

        // basic load
        clear_sb();
        exp_q.push_back({32'h0, 32'h00200093});
        start_frame();
        check("len0_state", 64'(oState), 64'(LEN0));
        check("len0_busy", 64'(oBusy), 64'd1);
        for (int i = 0; i < 7; i++) send_byte(basic_f[i], 0);
        check("basic_done", 64'({oDone, oErr, oCoreRst_n}), 64'b101);
        compare_writes("basic");

        // two words with random idle gaps
        clear_sb();
        exp_q.push_back({32'h0, 32'h00100113});
        exp_q.push_back({32'h4, 32'h00308193});
        start_frame();
        for (int i = 0; i < 11; i++) send_byte(two_f[i], $urandom_range(0, 3));
        check("two_done", 64'({oDone, oErr, oCoreRst_n}), 64'b101);
        check("two_pulse", 64'(wr_run_max), 64'd1);
        compare_writes("two");

        // bad checksum
        clear_sb();
        exp_q.push_back({32'h0, 32'h00200093});
        start_frame();
        for (int i = 0; i < 6; i++) send_byte(basic_f[i], 0);
        send_byte(8'hB3, 0);
        check("badcs_flags", 64'({oDone, oErr, oCoreRst_n}), 64'b010);
        compare_writes("badcs");

        // oversize length
        clear_sb();
        start_frame();
        check("ovs_err_cleared", 64'(oErr), 64'd0);
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        check("ovs_err", 64'(oErr), 64'd1);
        check("ovs_ready", 64'(oRxReady), 64'd0);
        check("ovs_busy", 64'(oBusy), 64'd0);
        tick();
        compare_writes("ovs");

        // empty frame, then restart
        clear_sb();
        start_frame();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("empty_done", 64'({oDone, oErr, oCoreRst_n}), 64'b101);
        compare_writes("empty");
        start_frame();
        check("restart_state", 64'(oState), 64'(LEN0));
        check("restart_flags", 64'({oDone, oCoreRst_n}), 64'b00);

        // reset mid-frame after 6 data bytes
        clear_sb();
        exp_q.push_back({32'h0, 32'h00100113});
        for (int i = 0; i < 8; i++) send_byte(two_f[i], 0);
        iRst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        iRst_n = 1'b1;
        repeat (4) tick();
        compare_writes("midrst");

        // fresh load after reset
        clear_sb();
        exp_q.push_back({32'h0, 32'h00200093});
        start_frame();
        for (int i = 0; i < 7; i++) send_byte(basic_f[i], 1);
        check("fresh_done", 64'({oDone, oErr, oCoreRst_n}), 64'b101);
        compare_writes("fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
